step_scheduler: RTL and testbench

Consumer end of the slow-tick path in the brick-breaker game: accepts the single-cycle enable pulses produced by the game delay counter, divides them by a speed setting, and turns each resulting step into a req/ack handshake with the game-update datapath (ball/paddle move logic). Steps arriving while the datapath is busy are queued in a saturating pending counter so no game step is silently lost. Sits between the tick generator and the game-state FSM.

---
 rtl/step_scheduler_if.sv | 26 ++
 rtl/step_scheduler.sv | 122 ++++++++++++
 tb/tb_step_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/step_scheduler_if.sv
// Handshake and status bundle between the tick source, the game-update datapath and step_scheduler.
// master drives tick/enable/speed/ack/clear; slave is the scheduler.
interface step_scheduler_if #(
    parameter int PEND_W = 3
);
    logic              tick;
    logic              enable;
    logic [1:0]        speed;
    logic              step_ack;
    logic              clear_flags;
    logic              step_req;
    logic [PEND_W-1:0] pending;
    logic [15:0]       step_count;
    logic              overrun;
    logic              timeout;

    modport master (
        output tick, enable, speed, step_ack, clear_flags,
        input  step_req, pending, step_count, overrun, timeout
    );

    modport slave (
        input  tick, enable, speed, step_ack, clear_flags,
        output step_req, pending, step_count, overrun, timeout
    );
endinterface

// File: rtl/step_scheduler.sv
// Divides delay-counter ticks by 1<<speed and issues each step as a req/ack handshake,
// queueing steps in a saturating pending counter. Optional request watchdog: STEP_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no request outstanding; leaves as soon as a step is pending
// REQ   | step_req high, waiting for step_ack (or watchdog expiry)
// GAP   | one forced low cycle of step_req between requests
module step_scheduler #(
    parameter int PEND_W  = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic             clock,
    input  logic             resetn,
    step_scheduler_if.slave  bus
);
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        div;
    logic [2:0]        div_thr;
    logic              step_evt;
    logic [PEND_W-1:0] pend;
    logic [15:0]       cnt;
    logic              ovr;
    logic              tmo;
    logic [WD_W-1:0]   wdog;
    logic              ack_done;
    logic              expire;
    logic              pend_dec;
    logic              pend_full;

    // >= rather than == so lowering speed mid-count fires on the very next tick
    assign div_thr  = 3'((4'd1 << bus.speed) - 4'd1);
    assign step_evt = bus.enable & bus.tick & (div >= div_thr);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            div <= '0;
        end else if (!bus.enable) begin
            div <= '0;
        end else if (bus.tick) begin
            div <= (div >= div_thr) ? 3'd0 : div + 3'd1;
        end
    end

    assign ack_done = (state == REQ) & bus.step_ack;

`ifdef STEP_TIMEOUT_EN
    // an ack arriving on the expiry cycle completes the step normally
    assign expire = (state == REQ) & ~bus.step_ack & (wdog == WD_W'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

    assign pend_dec  = ack_done | expire;
    assign pend_full = (pend == PEND_MAX);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wdog <= '0;
        end else if (state != REQ) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pend != '0) state_nxt = REQ;
            REQ:     if (pend_dec) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pend <= '0;
        end else if (step_evt && !pend_dec && !pend_full) begin
            pend <= pend + 1'b1;
        end else if (pend_dec && !step_evt) begin
            pend <= pend - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt <= '0;
            ovr <= 1'b0;
            tmo <= 1'b0;
        end else begin
            if (ack_done) cnt <= cnt + 16'd1;
            // a set in the same cycle as clear_flags wins
            ovr <= (step_evt & !pend_dec & pend_full) | (ovr & ~bus.clear_flags);
            tmo <= expire | (tmo & ~bus.clear_flags);
        end
    end

    assign bus.step_req   = (state == REQ);
    assign bus.pending    = pend;
    assign bus.step_count = cnt;
    assign bus.overrun    = ovr;
    assign bus.timeout    = tmo;
endmodule

// File: tb/tb_step_scheduler.sv
// Self-checking bench for step_scheduler: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_step_scheduler;
    localparam int PEND_W  = 3;
    localparam int TIMEOUT = 20;
    localparam int PMAX    = (1 << PEND_W) - 1;
`ifdef STEP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fails  = 0;

    step_scheduler_if #(.PEND_W(PEND_W)) bus ();

    step_scheduler #(.PEND_W(PEND_W), .TIMEOUT(TIMEOUT)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // model: a divider, a step queue, and a request that is either active,
    // in its mandatory low cycle, or absent
    int          m_div, m_pend, m_age;
    bit          m_req, m_gap, m_ovr, m_tmo;
    logic [15:0] m_cnt;

    task automatic model_update();
        bit ev, done, aband, dec;
        int pend_n;
        if (!resetn) begin
            m_div = 0; m_pend = 0; m_age = 0;
            m_req = 0; m_gap = 0; m_ovr = 0; m_tmo = 0; m_cnt = '0;
            return;
        end
        ev = 0;
        if (!bus.enable) m_div = 0;
        else if (bus.tick) begin
            if (m_div >= (1 << bus.speed) - 1) begin m_div = 0; ev = 1; end
            else m_div = m_div + 1;
        end
        done  = m_req && bus.step_ack;
        aband = TO_EN && m_req && !bus.step_ack && (m_age == TIMEOUT);
        dec   = done || aband;
        pend_n = m_pend;
        if (ev && !dec) begin
            if (m_pend == PMAX) m_ovr = 1;
            else pend_n = m_pend + 1;
        end else if (ev) begin
            pend_n = m_pend;
        end else if (dec) begin
            pend_n = m_pend - 1;
        end
        if (!(ev && !dec && m_pend == PMAX) && bus.clear_flags) m_ovr = 0;
        if (aband) m_tmo = 1;
        else if (bus.clear_flags) m_tmo = 0;
        if (done) m_cnt = m_cnt + 16'd1;
        if (m_req) begin
            if (dec) begin m_req = 0; m_gap = 1; end
            else m_age = m_age + 1;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_pend != 0) begin
            m_req = 1; m_age = 1;
        end
        m_pend = pend_n;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: model follows the edge, then every output is compared mid-cycle
    task automatic cyc();
        @(posedge clock);
        model_update();
        @(negedge clock);
        chk("step_req",   32'(bus.step_req),   32'(m_req));
        chk("pending",    32'(bus.pending),    32'(m_pend));
        chk("step_count", 32'(bus.step_count), 32'(m_cnt));
        chk("overrun",    32'(bus.overrun),    32'(m_ovr));
        chk("timeout",    32'(bus.timeout),    32'(m_tmo));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [15:0] c0;

    initial begin
        resetn = 1'b0;
        bus.tick = 0; bus.enable = 0; bus.speed = 2'd0;
        bus.step_ack = 0; bus.clear_flags = 0;
        m_div = 0; m_pend = 0; m_age = 0; m_req = 0; m_gap = 0;
        m_ovr = 0; m_tmo = 0; m_cnt = '0;
        run(2);
        chk("rst_req",   32'(bus.step_req),   32'd0);
        chk("rst_pend",  32'(bus.pending),    32'd0);
        chk("rst_count", 32'(bus.step_count), 32'd0);
        chk("rst_ovr",   32'(bus.overrun),    32'd0);
        resetn = 1'b1;
        bus.enable = 1;

        // single tick, speed 0
        bus.tick = 1; cyc(); bus.tick = 0;
        chk("t1_pend_after_N", 32'(bus.pending), 32'd1);
        chk("t1_req_after_N",  32'(bus.step_req), 32'd0);
        cyc();
        chk("t1_req_after_N1", 32'(bus.step_req), 32'd1);
        cyc();
        bus.step_ack = 1; cyc(); bus.step_ack = 0;
        chk("t1_count", 32'(bus.step_count), 32'd1);
        chk("t1_pend",  32'(bus.pending),    32'd0);
        chk("t1_req",   32'(bus.step_req),   32'd0);
        run(2);

        // saturation, clear, drain
        bus.tick = 1; run(10); bus.tick = 0;
        chk("sat_pend", 32'(bus.pending), 32'd7);
        chk("sat_ovr",  32'(bus.overrun), 32'd1);
        bus.clear_flags = 1; cyc(); bus.clear_flags = 0;
        chk("clr_ovr", 32'(bus.overrun), 32'd0);
        bus.step_ack = 1; run(25); bus.step_ack = 0;
        chk("drain_count", 32'(bus.step_count), 32'd8);
        chk("drain_pend",  32'(bus.pending),    32'd0);

        // request with no ack for 110 cycles
        bus.tick = 1; cyc(); bus.tick = 0;
        run(110);
`ifdef STEP_TIMEOUT_EN
        chk("to_req",   32'(bus.step_req),   32'd0);
        chk("to_flag",  32'(bus.timeout),    32'd1);
        chk("to_count", 32'(bus.step_count), 32'd8);
`else
        chk("nto_req",  32'(bus.step_req),   32'd1);
        chk("nto_flag", 32'(bus.timeout),    32'd0);
`endif
        bus.step_ack = 1; run(3); bus.step_ack = 0;
        bus.clear_flags = 1; cyc(); bus.clear_flags = 0;
        chk("clr_tmo", 32'(bus.timeout), 32'd0);

        // speed 2: eight ticks give two steps
        bus.enable = 0; cyc(); bus.enable = 1;
        c0 = bus.step_count;
        bus.speed = 2'd2; bus.step_ack = 1;
        bus.tick = 1; run(8); bus.tick = 0;
        run(8);
        chk("spd2_count", 32'(bus.step_count), 32'(c0 + 16'd2));

        // speed 3 -> 0 with divider at 5 steps on the next tick
        bus.enable = 0; cyc(); bus.enable = 1;
        bus.speed = 2'd3;
        bus.tick = 1; run(5);
        chk("spd3_nostep", 32'(bus.pending), 32'd0);
        bus.speed = 2'd0; cyc(); bus.tick = 0;
        chk("spd_drop_step", 32'(bus.pending), 32'd1);
        run(4); bus.step_ack = 0;

        // reset mid-handshake with four queued
        bus.tick = 1; run(4); bus.tick = 0;
        chk("pre_rst_pend", 32'(bus.pending), 32'd4);
        chk("pre_rst_req",  32'(bus.step_req), 32'd1);
        resetn = 0; cyc(); resetn = 1;
        chk("mid_rst_req",   32'(bus.step_req),   32'd0);
        chk("mid_rst_pend",  32'(bus.pending),    32'd0);
        chk("mid_rst_count", 32'(bus.step_count), 32'd0);
        bus.enable = 0; bus.tick = 1; run(6); bus.tick = 0;
        chk("dis_req",  32'(bus.step_req), 32'd0);
        chk("dis_pend", 32'(bus.pending),  32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bus.tick        = ($urandom_range(0, 1) == 1);
            bus.enable      = ($urandom_range(0, 15) != 0);
            bus.step_ack    = (i < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            bus.clear_flags = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 31) == 0) bus.speed = 2'($urandom_range(0, 3));
            resetn = ($urandom_range(0, 499) != 0);
            cyc();
        end
        resetn = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
